// File: rtl/jump_tick_sched_if.sv
// Bundles the update-pass handshake, control and status signals between the
// scheduler (slave) and the game logic that drives it (master).
interface jump_tick_sched_if #(
   parameter int DIV_W = 18
);
   logic             en;
   logic             pause;
   logic             cfg_we;
   logic [DIV_W-1:0] cfg_period;
   logic             tick;
   logic             phys_req;
   logic             phys_ack;
   logic             coll_req;
   logic             coll_ack;
   logic             upd_done;
   logic             busy;
   logic             overrun;
   logic             timeout_err;

   modport master (
      output en, pause, cfg_we, cfg_period, phys_ack, coll_ack,
      input  tick, phys_req, coll_req, upd_done, busy, overrun, timeout_err
   );

   modport slave (
      input  en, pause, cfg_we, cfg_period, phys_ack, coll_ack,
      output tick, phys_req, coll_req, upd_done, busy, overrun, timeout_err
   );
endinterface

// File: rtl/jump_tick_sched.sv
// Game-update scheduler: programmable-period tick strobe, then one physics and
// one collision req/ack phase per tick, each guarded by a watchdog.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | waiting for a tick
//   PHYS   | phys_req high, waiting for phys_ack
//   COLL   | coll_req high, waiting for coll_ack
//   DONE   | upd_done pulse, back to IDLE next cycle
module jump_tick_sched #(
   parameter int               DIV_W      = 18,
   parameter logic [DIV_W-1:0] DEF_PERIOD = {DIV_W{1'b1}},
   parameter int               TO_W       = 8,
   parameter int               TO_LIMIT   = 255
) (
   input logic               i_clk_vga,
   input logic               i_rst,
   jump_tick_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PHYS = 2'd1,
      S_COLL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] WDOG_LIMIT = TO_W'(TO_LIMIT);

   logic [DIV_W-1:0] r_period;
   logic [DIV_W-1:0] r_cnt;
   logic             r_tick;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [TO_W-1:0]  r_wdog;
   logic [TO_W-1:0]  w_wdog_nxt;
   logic             w_timeout;
   logic             r_overrun;
   logic             r_timeout_err;

   // Period 0 would tick every cycle; clamp so tick can never be high twice in a row.
   always_ff @(posedge i_clk_vga) begin
      if (i_rst) begin
         r_period <= DEF_PERIOD;
         r_cnt    <= '0;
         r_tick   <= 1'b0;
      end else if (bus.cfg_we) begin
         r_period <= (bus.cfg_period == '0) ? DIV_W'(1) : bus.cfg_period;
         r_cnt    <= '0;
         r_tick   <= 1'b0;
      end else if (!bus.en) begin
         r_cnt    <= '0;
         r_tick   <= 1'b0;
      end else if (bus.pause) begin
         r_tick   <= 1'b0;
      end else if (r_cnt == r_period) begin
         r_cnt    <= '0;
         r_tick   <= 1'b1;
      end else begin
         r_cnt    <= r_cnt + DIV_W'(1);
         r_tick   <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wdog_nxt  = r_wdog;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_tick && bus.en) begin
               w_state_nxt = S_PHYS;
               w_wdog_nxt  = '0;
            end
         end
         S_PHYS: begin
            if (!bus.en) begin
               w_state_nxt = S_IDLE;
            end else if (bus.phys_ack) begin
               w_state_nxt = S_COLL;
               w_wdog_nxt  = '0;
            end else if (r_wdog == WDOG_LIMIT) begin
               w_state_nxt = S_IDLE;
               w_timeout   = 1'b1;
            end else begin
               w_wdog_nxt  = r_wdog + TO_W'(1);
            end
         end
         S_COLL: begin
            if (!bus.en) begin
               w_state_nxt = S_IDLE;
            end else if (bus.coll_ack) begin
               w_state_nxt = S_DONE;
            end else if (r_wdog == WDOG_LIMIT) begin
               w_state_nxt = S_IDLE;
               w_timeout   = 1'b1;
            end else begin
               w_wdog_nxt  = r_wdog + TO_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // A reconfiguration clears the sticky flags even if an event lands the same cycle.
   always_ff @(posedge i_clk_vga) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_wdog        <= '0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wdog  <= w_wdog_nxt;
         if (bus.cfg_we) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
         end else begin
            if (r_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
         end
      end
   end

   assign bus.tick        = r_tick;
   assign bus.phys_req    = (r_state == S_PHYS);
   assign bus.coll_req    = (r_state == S_COLL);
   assign bus.upd_done    = (r_state == S_DONE);
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.overrun     = r_overrun;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_jump_tick_sched.sv
// Bench for jump_tick_sched: cycle-level behavioural model compared on every
// negedge, directed scenarios with literal timing checks, then random traffic.
module tb_jump_tick_sched;
   localparam int DIV_W    = 18;
   localparam int TO_LIMIT = 255;
   localparam int DEF_P    = 262143;

   logic clk_vga = 1'b0;
   logic rst;
   always #5 clk_vga = ~clk_vga;

   jump_tick_sched_if #(.DIV_W(DIV_W)) bus ();

   jump_tick_sched #(
      .DIV_W(DIV_W), .DEF_PERIOD(18'h3FFFF), .TO_W(8), .TO_LIMIT(TO_LIMIT)
   ) dut (
      .i_clk_vga(clk_vga),
      .i_rst    (rst),
      .bus      (bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at cycle", name, act, exp);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 physics, 2 collision, 3 done.
   int m_period = DEF_P, m_cnt = 0, m_phase = 0, m_wait = 0;
   bit m_tick = 0, m_ovr = 0, m_terr = 0;
   int cyc = 0;

   always @(posedge clk_vga) begin
      cyc++;
      if (rst) begin
         m_period = DEF_P; m_cnt = 0; m_tick = 0;
         m_phase = 0; m_wait = 0; m_ovr = 0; m_terr = 0;
      end else begin
         if (m_phase != 0 && m_tick) m_ovr = 1'b1;
         case (m_phase)
            0: if (m_tick && bus.en) begin m_phase = 1; m_wait = 0; end
            1, 2: begin
               if (!bus.en) m_phase = 0;
               else if ((m_phase == 1) ? bus.phys_ack : bus.coll_ack) begin
                  m_phase = m_phase + 1; m_wait = 0;
               end else if (m_wait == TO_LIMIT) begin
                  m_phase = 0; m_terr = 1'b1;
               end else m_wait++;
            end
            default: m_phase = 0;
         endcase
         if (bus.cfg_we) begin
            m_ovr = 0; m_terr = 0;
            m_period = (bus.cfg_period == 0) ? 1 : int'(bus.cfg_period);
            m_cnt = 0; m_tick = 0;
         end else if (!bus.en) begin
            m_cnt = 0; m_tick = 0;
         end else if (bus.pause) begin
            m_tick = 0;
         end else if (m_cnt == m_period) begin
            m_cnt = 0; m_tick = 1;
         end else begin
            m_cnt++; m_tick = 0;
         end
      end
   end

   // Compare process plus DUT-side measurements for the literal checks.
   int last_tick = 0, tick_gap = 0, done_gap = 0, tick_cnt = 0, done_cnt = 0;
   int phys_run = 0, phys_len = 0, coll_run = 0, coll_len = 0;

   always @(negedge clk_vga) begin
      if (chk_on) begin
         chk("tick",        32'(bus.tick),        32'(m_tick));
         chk("phys_req",    32'(bus.phys_req),    32'(m_phase == 1));
         chk("coll_req",    32'(bus.coll_req),    32'(m_phase == 2));
         chk("upd_done",    32'(bus.upd_done),    32'(m_phase == 3));
         chk("busy",        32'(bus.busy),        32'(m_phase != 0));
         chk("overrun",     32'(bus.overrun),     32'(m_ovr));
         chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
      end
      if (bus.tick === 1'b1) begin
         tick_gap = cyc - last_tick; last_tick = cyc; tick_cnt++;
      end
      if (bus.upd_done === 1'b1) begin
         done_gap = cyc - last_tick; done_cnt++;
      end
      if (bus.phys_req === 1'b1) phys_run++;
      else begin if (phys_run > 0) phys_len = phys_run; phys_run = 0; end
      if (bus.coll_req === 1'b1) coll_run++;
      else begin if (coll_run > 0) coll_len = coll_run; coll_run = 0; end
   end

   // Ack responder: acks after the chosen number of wait cycles in its phase.
   int phys_dly = 0, coll_dly = 0;
   bit junk = 1'b0;

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk_vga);
         #1;
         bus.phys_ack = (m_phase == 1) ? (m_wait >= phys_dly) : (junk && $urandom_range(0, 3) == 0);
         bus.coll_ack = (m_phase == 2) ? (m_wait >= coll_dly) : (junk && $urandom_range(0, 3) == 0);
      end
   endtask

   task automatic wait_tick(input int budget);
      int n;
      n = 0;
      do begin step(1); n++; end while (bus.tick !== 1'b1 && n < budget);
      chk("wait_tick", 32'(bus.tick), 1);
   endtask

   task automatic restart(input int p, input int pd, input int cd);
      bus.en = 1'b0; bus.pause = 1'b0;
      step(2);
      bus.cfg_we = 1'b1; bus.cfg_period = DIV_W'(p);
      step(1);
      bus.cfg_we = 1'b0; bus.en = 1'b1;
      phys_dly = pd; coll_dly = cd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tick"},     32'(bus.tick), 0);
      chk({tag, "_phys_req"}, 32'(bus.phys_req), 0);
      chk({tag, "_coll_req"}, 32'(bus.coll_req), 0);
      chk({tag, "_upd_done"}, 32'(bus.upd_done), 0);
      chk({tag, "_busy"},     32'(bus.busy), 0);
      chk({tag, "_overrun"},  32'(bus.overrun), 0);
      chk({tag, "_timeout"},  32'(bus.timeout_err), 0);
   endtask

   function automatic int pick_dly();
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) return 300;
      if (r < 40) return 0;
      return $urandom_range(0, 8);
   endfunction

   int d0, c0, t0;

   initial begin
      rst = 1'b1;
      bus.en = 1'b0; bus.pause = 1'b0; bus.cfg_we = 1'b0; bus.cfg_period = '0;
      bus.phys_ack = 1'b0; bus.coll_ack = 1'b0;
      step(2);
      chk_on = 1'b1;
      chk_all_zero("reset");
      rst = 1'b0;

      // Period 4, immediate acks.
      restart(4, 0, 0);
      wait_tick(20);
      step(12);
      chk("p4_tick_gap", 32'(tick_gap), 5);
      chk("p4_done_gap", 32'(done_gap), 3);
      chk("p4_phys_len", 32'(phys_len), 1);
      chk("p4_overrun",  32'(bus.overrun), 0);

      // Period 9, delayed acks.
      restart(9, 6, 3);
      wait_tick(20);
      d0 = done_cnt;
      step(13);
      chk("p9_phys_len", 32'(phys_len), 7);
      chk("p9_coll_len", 32'(coll_len), 4);
      chk("p9_done_one", 32'(done_cnt - d0), 1);
      chk("p9_busy_low", 32'(bus.busy), 0);

      // Overrun set, sticky, cleared by cfg_we.
      restart(2, 10, 10);
      chk("ovr_cleared", 32'(bus.overrun), 0);
      step(15);
      chk("ovr_set",    32'(bus.overrun), 1);
      step(10);
      chk("ovr_sticky", 32'(bus.overrun), 1);
      bus.cfg_we = 1'b1; bus.cfg_period = DIV_W'(2);
      step(1);
      bus.cfg_we = 1'b0;
      chk("ovr_cfg_clr", 32'(bus.overrun), 0);

      // Collision watchdog expiry, then a normal pass.
      restart(300, 0, 1000);
      wait_tick(400);
      d0 = done_cnt;
      step(300);
      chk("to_coll_len", 32'(coll_len), 256);
      chk("to_err",      32'(bus.timeout_err), 1);
      chk("to_idle",     32'(bus.busy), 0);
      chk("to_no_done",  32'(done_cnt - d0), 0);
      coll_dly = 0;
      wait_tick(400);
      d0 = done_cnt;
      step(4);
      chk("to_recover_done", 32'(done_cnt - d0), 1);

      // Pause at cnt=3 for 20 cycles with a sequence in flight.
      restart(9, 4, 0);
      wait_tick(20);
      d0 = done_cnt;
      step(3);
      bus.pause = 1'b1;
      t0 = tick_cnt;
      step(20);
      chk("pause_no_tick", 32'(tick_cnt - t0), 0);
      chk("pause_done",    32'(done_cnt - d0), 1);
      bus.pause = 1'b0;
      c0 = cyc;
      wait_tick(20);
      chk("pause_resume_gap", 32'(cyc - c0), 7);

      // Abort during physics.
      restart(5, 1000, 0);
      chk("abort_terr_clr", 32'(bus.timeout_err), 0);
      wait_tick(20);
      step(2);
      d0 = done_cnt;
      bus.en = 1'b0;
      step(1);
      chk("abort_phys_req", 32'(bus.phys_req), 0);
      chk("abort_busy",     32'(bus.busy), 0);
      step(2);
      chk("abort_no_done",  32'(done_cnt - d0), 0);
      chk("abort_no_terr",  32'(bus.timeout_err), 0);

      // Period 0 clamps to 1.
      restart(0, 0, 0);
      wait_tick(10);
      wait_tick(10);
      chk("clamp_gap", 32'(tick_gap), 2);

      // Reset in the middle of the collision phase.
      restart(20, 0, 1000);
      wait_tick(40);
      step(3);
      chk("pre_rst_coll", 32'(bus.coll_req), 1);
      rst = 1'b1;
      step(1);
      chk_all_zero("midrst");
      rst = 1'b0;

      // Random traffic.
      junk = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 599) == 0);
         bus.en        = ($urandom_range(0, 99) != 0);
         bus.pause     = ($urandom_range(0, 19) == 0);
         bus.cfg_we    = (i == 0) || ($urandom_range(0, 99) == 0);
         bus.cfg_period = DIV_W'($urandom_range(0, 12));
         if (m_phase == 0) begin
            phys_dly = pick_dly();
            coll_dly = pick_dly();
         end
         step(1);
      end
      rst = 1'b0; bus.cfg_we = 1'b0;
      step(2);
      chk_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
